// File: rtl/senone_topk.sv
// Streaming top-K tracker for senone scores: keeps the K best (score, id) pairs of a
// frame in rank order, reports best score and beam threshold, then drains the list.
module senone_topk #(
  parameter int W   = 16,
  parameter int IDW = 13,
  parameter int K   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 frame_start,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [W-1:0]                         in_score,
  input  logic [IDW-1:0]                       in_id,
  input  logic                                 in_last,
  input  logic [W-1:0]                         beam,
  output logic [W-1:0]                         best_score,
  output logic [IDW-1:0]                       best_id,
  output logic [W-1:0]                         threshold,
  output logic [$clog2(K+1)-1:0]               fill,
  output logic                                 done,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [W-1:0]                         out_score,
  output logic [IDW-1:0]                       out_id,
  output logic [((K > 1) ? $clog2(K) : 1)-1:0] out_rank,
  output logic                                 out_last,
  output logic [1:0]                           state_dbg
);

  // Both ports are valid/ready: a beat moves on a cycle where valid & ready are high,
  // and a frame_start in the same cycle discards the beat.
  localparam int FW = $clog2(K+1);
  localparam int RW = (K > 1) ? $clog2(K) : 1;
  localparam logic [FW-1:0] K_F       = FW'(K);
  localparam logic [W-1:0]  MIN_SCORE = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     score_q [K];
  logic [W-1:0]     score_d [K];
  logic [IDW-1:0]   id_q [K];
  logic [IDW-1:0]   id_d [K];
  logic [FW-1:0]    fill_q, fill_d;
  logic [RW-1:0]    rank_q, rank_d;
  logic             done_q, done_d;
  logic             accept, xfer;
  logic [K-1:0]     gt;
  logic             ins_en;
  logic [RW-1:0]    ins_pos;
  logic [W:0]       diff;

  assign accept = in_valid & (state_q == COLLECT) & ~frame_start;
  assign xfer   = out_ready & (state_q == DRAIN) & ~frame_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: ;
      COLLECT: begin
        in_ready = 1'b1;
        if (accept && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (xfer && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (frame_start) state_d = COLLECT;
  end

  // Strict > keeps the earlier sample ahead on ties; the lowest matching rank wins.
  always_comb begin
    gt      = '0;
    ins_en  = 1'b0;
    ins_pos = '0;
    for (int i = 0; i < K; i++)
      gt[i] = (FW'(i) < fill_q) && ($signed(in_score) > $signed(score_q[i]));
    if (fill_q != K_F) begin
      ins_en  = 1'b1;
      ins_pos = fill_q[RW-1:0];
    end
    for (int i = K-1; i >= 0; i--) begin
      if (gt[i]) begin
        ins_en  = 1'b1;
        ins_pos = RW'(i);
      end
    end
  end

  always_comb begin
    score_d = score_q;
    id_d    = id_q;
    fill_d  = fill_q;
    rank_d  = rank_q;
    done_d  = 1'b0;
    if (frame_start) begin
      for (int i = 0; i < K; i++) begin
        score_d[i] = MIN_SCORE;
        id_d[i]    = '0;
      end
      fill_d = '0;
      rank_d = '0;
    end else begin
      if (accept && ins_en) begin
        for (int i = 1; i < K; i++) begin
          if (RW'(i) > ins_pos) begin
            score_d[i] = score_q[i-1];
            id_d[i]    = id_q[i-1];
          end
        end
        score_d[ins_pos] = in_score;
        id_d[ins_pos]    = in_id;
        if (fill_q != K_F) fill_d = fill_q + 1'b1;
      end
      if (accept && in_last) begin
        done_d = 1'b1;
        rank_d = '0;
      end
      if (xfer) rank_d = out_last ? '0 : rank_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < K; i++) begin
        score_q[i] <= MIN_SCORE;
        id_q[i]    <= '0;
      end
      fill_q <= '0;
      rank_q <= '0;
      done_q <= 1'b0;
    end else begin
      score_q <= score_d;
      id_q    <= id_d;
      fill_q  <= fill_d;
      rank_q  <= rank_d;
      done_q  <= done_d;
    end
  end

  // Sign-extended best minus zero-extended beam; a carry out of the W-bit range clamps.
  assign diff       = {score_q[0][W-1], score_q[0]} - {1'b0, beam};
  assign threshold  = (diff[W] != diff[W-1]) ? MIN_SCORE : diff[W-1:0];

  assign best_score = score_q[0];
  assign best_id    = id_q[0];
  assign fill       = fill_q;
  assign done       = done_q;
  assign out_score  = score_q[rank_q];
  assign out_id     = id_q[rank_q];
  assign out_rank   = rank_q;
  assign out_last   = ((FW'(rank_q) + FW'(1)) == fill_q);
  assign state_dbg  = state_q;

endmodule
